// File: rtl/leon_stim_pkg.sv
// Shared types and constants for the leon_stim_responder stimulus/response model.
package leon_stim_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h01000000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dc_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_rec_t;

  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/leon_stim_fifo.sv
// Generic synchronous FIFO (module stim_fifo); extra pointer bit separates full from empty.
module stim_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot a same-cycle push into a full FIFO needs
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/leon_stim_responder.sv
// Clocked instruction/data responder for the IU cache ports.
// Optional random fetch stalls are enabled with `define LEON_STIM_STALL_EN.
module leon_stim_responder
  import leon_stim_pkg::*;
#(
  parameter int          INST_DEPTH = 16,
  parameter int          LD_DEPTH   = 8,
  parameter int          ST_DEPTH   = 8,
  parameter int          LOAD_LAT   = 2,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_push,
  input  logic [31:0] inst_wdata,
  output logic        inst_full,
  input  logic        ld_push,
  input  logic [31:0] ld_wdata,
  output logic        ld_full,
  input  logic        ic_req,
  output logic [31:0] ic_data,
  output logic        ic_valid,
  output logic        ic_hold,
  input  logic        dc_req,
  input  logic        dc_write,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic [31:0] dc_rdata,
  output logic        dc_mds,
  output logic        dc_hold,
  input  logic        st_pop,
  output logic [31:0] st_addr,
  output logic [31:0] st_data,
  output logic        st_valid,
  output logic [15:0] ic_underflow_cnt,
  output logic [2:0]  err_flags
);

  localparam logic [3:0] LAT_M1 = (LOAD_LAT == 0) ? 4'd0 : 4'(LOAD_LAT - 1);

  logic [31:0] ic_head, ld_head;
  logic        ic_empty, ld_empty, st_full, st_empty;
  logic        ic_service, ic_pop, ld_pop, st_push;
  logic        inst_ovf, st_ovf, ld_uf;
  st_rec_t     st_rec, st_head;
  dc_state_t   state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        mds_nxt;

`ifdef LEON_STIM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end

  assign ic_hold = (lfsr[1:0] == 2'b00);
`else
  assign ic_hold = 1'b0;
`endif

  stim_fifo #(.WIDTH(32), .DEPTH(INST_DEPTH)) u_inst_fifo (
    .clk(clk), .rst(rst), .push(inst_push), .wdata(inst_wdata), .pop(ic_pop),
    .rdata(ic_head), .full(inst_full), .empty(ic_empty)
  );

  stim_fifo #(.WIDTH(32), .DEPTH(LD_DEPTH)) u_ld_fifo (
    .clk(clk), .rst(rst), .push(ld_push), .wdata(ld_wdata), .pop(ld_pop),
    .rdata(ld_head), .full(ld_full), .empty(ld_empty)
  );

  stim_fifo #(.WIDTH($bits(st_rec_t)), .DEPTH(ST_DEPTH)) u_st_fifo (
    .clk(clk), .rst(rst), .push(st_push), .wdata(st_rec), .pop(st_pop),
    .rdata(st_head), .full(st_full), .empty(st_empty)
  );

  assign st_rec     = '{addr: dc_addr, data: dc_wdata};
  assign st_addr    = st_head.addr;
  assign st_data    = st_head.data;
  assign st_valid   = ~st_empty;
  assign ic_service = ic_req & ~ic_hold;
  assign ic_pop     = ic_service & ~ic_empty;
  assign inst_ovf   = inst_push & inst_full & ~ic_pop;
  assign st_ovf     = st_push & st_full & ~st_pop;
  assign ld_uf      = (state == RESP) & ld_empty;
  assign dc_hold    = (state != IDLE);

  // Fetch answers one cycle after a serviced request; an empty FIFO answers NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_valid         <= 1'b0;
      ic_data          <= NOP_INST;
      ic_underflow_cnt <= 16'h0000;
    end else begin
      ic_valid <= ic_service;
      if (ic_service) begin
        ic_data <= ic_empty ? NOP_INST : ic_head;
        if (ic_empty && ic_underflow_cnt != 16'hFFFF)
          ic_underflow_cnt <= ic_underflow_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st_push   = 1'b0;
    ld_pop    = 1'b0;
    mds_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (dc_req) begin
          if (dc_write) begin
            st_push = 1'b1;
            mds_nxt = 1'b1;
          end else if (LOAD_LAT == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP: begin
        ld_pop    = 1'b1;
        mds_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      dc_mds    <= 1'b0;
      dc_rdata  <= 32'h0;
      err_flags <= 3'b000;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dc_mds    <= mds_nxt;
      if (state == RESP) dc_rdata <= ld_empty ? 32'h0 : ld_head;
      err_flags <= err_flags | {ld_uf, st_ovf, inst_ovf};
    end
  end

endmodule

// File: tb/tb_leon_stim_responder.sv
// Scoreboard bench for leon_stim_responder; a second instance checks LOAD_LAT=0 timing.
module tb_leon_stim_responder;

  localparam logic [31:0] NOP = 32'h01000000;

  typedef struct {
    bit          isLoad;
    logic [31:0] data;
  } dcExp_t;

  logic        clk = 1'b0;
  logic        rst, inst_push, ld_push, ic_req, dc_req, dc_write, st_pop;
  logic [31:0] inst_wdata, ld_wdata, dc_addr, dc_wdata;
  logic        inst_full, ld_full, ic_valid, ic_hold, dc_mds, dc_hold, st_valid;
  logic [31:0] ic_data, dc_rdata, st_addr, st_data;
  logic [15:0] ic_underflow_cnt;
  logic [2:0]  err_flags;
  logic        z_inst_full, z_ld_full, z_ic_valid, z_ic_hold, z_dc_mds, z_dc_hold, z_st_valid;
  logic [31:0] z_ic_data, z_dc_rdata, z_st_addr, z_st_data;
  logic [15:0] z_ic_underflow_cnt;
  logic [2:0]  z_err_flags;

  logic [31:0] expIc[$];
  dcExp_t      expDc[$];
  logic [31:0] monIc;
  dcExp_t      monDc;
  logic [15:0] refLfsr;
  int          errors = 0;
  int          checks = 0;

  leon_stim_responder #(.LOAD_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .inst_push(inst_push), .inst_wdata(inst_wdata), .inst_full(inst_full),
    .ld_push(ld_push), .ld_wdata(ld_wdata), .ld_full(ld_full),
    .ic_req(ic_req), .ic_data(ic_data), .ic_valid(ic_valid), .ic_hold(ic_hold),
    .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_mds(dc_mds), .dc_hold(dc_hold),
    .st_pop(st_pop), .st_addr(st_addr), .st_data(st_data), .st_valid(st_valid),
    .ic_underflow_cnt(ic_underflow_cnt), .err_flags(err_flags)
  );

  leon_stim_responder #(.LOAD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .inst_push(inst_push), .inst_wdata(inst_wdata), .inst_full(z_inst_full),
    .ld_push(ld_push), .ld_wdata(ld_wdata), .ld_full(z_ld_full),
    .ic_req(ic_req), .ic_data(z_ic_data), .ic_valid(z_ic_valid), .ic_hold(z_ic_hold),
    .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(z_dc_rdata), .dc_mds(z_dc_mds), .dc_hold(z_dc_hold),
    .st_pop(st_pop), .st_addr(z_st_addr), .st_data(z_st_data), .st_valid(z_st_valid),
    .ic_underflow_cnt(z_ic_underflow_cnt), .err_flags(z_err_flags)
  );

  always #5 clk = ~clk;

  // Reference stall generator: x^16+x^14+x^13+x^11+1, seed ACE1
  always @(posedge clk) begin
    if (rst) refLfsr <= 16'hACE1;
    else     refLfsr <= {1'b0, refLfsr[15:1]} ^ (refLfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One serviced fetch, waiting out any stall; optional push lands in the serviced cycle
  task automatic applyStimulus(input logic [31:0] expWord, input bit doPush, input logic [31:0] pushWord);
    int n;
    n = 0;
    ic_req = 1'b1;
    while (ic_hold && n < 32) begin
      tick();
      n++;
    end
    checkOutput("ic_stall_bound", {31'b0, ic_hold}, 32'd0);
    inst_push  = doPush;
    inst_wdata = pushWord;
    expIc.push_back(expWord);
    tick();
    ic_req    = 1'b0;
    inst_push = 1'b0;
  endtask

  // Scoreboard side: every fetch response and data strobe must match a queued expectation
  always @(negedge clk) begin
    if (ic_valid) begin
      checkOutput("ic_valid_expected", {31'b0, expIc.size() != 0}, 32'd1);
      if (expIc.size() != 0) begin
        monIc = expIc.pop_front();
        checkOutput("ic_data", ic_data, monIc);
      end
    end
    if (dc_mds) begin
      checkOutput("dc_mds_expected", {31'b0, expDc.size() != 0}, 32'd1);
      if (expDc.size() != 0) begin
        monDc = expDc.pop_front();
        if (monDc.isLoad) checkOutput("dc_rdata", dc_rdata, monDc.data);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int k;
    logic expHold;
    rst = 1'b1; inst_push = 1'b0; ld_push = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
    dc_write = 1'b0; st_pop = 1'b0; inst_wdata = '0; ld_wdata = '0; dc_addr = '0; dc_wdata = '0;
    repeat (3) tick();
    checkOutput("rst_ic_data", ic_data, NOP);
    checkOutput("rst_ic_valid", {31'b0, ic_valid}, 32'd0);
    checkOutput("rst_ic_hold", {31'b0, ic_hold}, 32'd0);
    checkOutput("rst_dc_rdata", dc_rdata, 32'd0);
    checkOutput("rst_dc_mds", {31'b0, dc_mds}, 32'd0);
    checkOutput("rst_dc_hold", {31'b0, dc_hold}, 32'd0);
    checkOutput("rst_st_valid", {31'b0, st_valid}, 32'd0);
    checkOutput("rst_uf_cnt", {16'b0, ic_underflow_cnt}, 32'd0);
    checkOutput("rst_err", {29'b0, err_flags}, 32'd0);
    rst = 1'b0;

    $display("[TB] two queued instructions");
    inst_push = 1'b1; inst_wdata = 32'h8E00C002; tick();
    inst_wdata = 32'h01000000; tick();
    inst_push = 1'b0;
    applyStimulus(32'h8E00C002, 1'b0, '0);
    applyStimulus(32'h01000000, 1'b0, '0);
    tick();
    checkOutput("ic_idle_valid", {31'b0, ic_valid}, 32'd0);
    checkOutput("ic_idle_hold_data", ic_data, 32'h01000000);
    checkOutput("uf_cnt_after_words", {16'b0, ic_underflow_cnt}, 32'd0);

    $display("[TB] underflow fetches");
    repeat (3) applyStimulus(NOP, 1'b0, '0);
    tick();
    checkOutput("uf_cnt_3", {16'b0, ic_underflow_cnt}, 32'd3);

    $display("[TB] instruction FIFO full / overflow");
    for (int i = 0; i < 16; i++) begin
      inst_push = 1'b1; inst_wdata = 32'h10000000 + 32'(i); tick();
    end
    inst_push = 1'b0;
    checkOutput("inst_full", {31'b0, inst_full}, 32'd1);
    checkOutput("inst_ovf_clear", {31'b0, err_flags[0]}, 32'd0);
    applyStimulus(32'h10000000, 1'b1, 32'h10000010);
    checkOutput("inst_full_pushpop", {31'b0, inst_full}, 32'd1);
    checkOutput("inst_ovf_pushpop", {31'b0, err_flags[0]}, 32'd0);
    inst_push = 1'b1; inst_wdata = 32'hBAD0BAD0; tick(); inst_push = 1'b0;
    checkOutput("inst_ovf_set", {31'b0, err_flags[0]}, 32'd1);
    for (int i = 1; i <= 16; i++) applyStimulus(32'h10000000 + 32'(i), 1'b0, '0);
    tick();
    checkOutput("inst_drained_full", {31'b0, inst_full}, 32'd0);

    $display("[TB] continuous fetch, 64 cycles");
    for (int i = 0; i < 16; i++) begin
      inst_push = 1'b1; inst_wdata = 32'h20000000 + 32'(i); tick();
    end
    inst_push = 1'b0;
    k = 0;
    ic_req = 1'b1;
    for (int c = 0; c < 64; c++) begin
`ifdef LEON_STIM_STALL_EN
      expHold = (refLfsr[1:0] == 2'b00);
`else
      expHold = 1'b0;
`endif
      checkOutput("ic_hold_pattern", {31'b0, ic_hold}, {31'b0, expHold});
      if (!expHold) begin
        expIc.push_back((k < 16) ? 32'h20000000 + 32'(k) : NOP);
        k++;
      end
      tick();
    end
    ic_req = 1'b0;
    tick();

    $display("[TB] load, LOAD_LAT=2 and LOAD_LAT=0");
    ld_push = 1'b1; ld_wdata = 32'h00000013; tick(); ld_push = 1'b0;
    dc_req = 1'b1; dc_write = 1'b0; dc_addr = 32'h100;
    expDc.push_back('{isLoad: 1'b1, data: 32'h13});
    tick(); dc_req = 1'b0;
    checkOutput("ld_hold_c1", {31'b0, dc_hold}, 32'd1);
    checkOutput("ld0_hold_c1", {31'b0, z_dc_hold}, 32'd1);
    checkOutput("ld0_mds_c1", {31'b0, z_dc_mds}, 32'd0);
    tick();
    checkOutput("ld_hold_c2", {31'b0, dc_hold}, 32'd1);
    checkOutput("ld_mds_c2", {31'b0, dc_mds}, 32'd0);
    checkOutput("ld0_mds_c2", {31'b0, z_dc_mds}, 32'd1);
    checkOutput("ld0_rdata", z_dc_rdata, 32'h13);
    checkOutput("ld0_hold_c2", {31'b0, z_dc_hold}, 32'd0);
    tick();
    checkOutput("ld_hold_c3", {31'b0, dc_hold}, 32'd1);
    checkOutput("ld_mds_c3", {31'b0, dc_mds}, 32'd0);
    tick();
    checkOutput("ld_mds_c4", {31'b0, dc_mds}, 32'd1);
    checkOutput("ld_hold_c4", {31'b0, dc_hold}, 32'd0);
    tick();
    checkOutput("ld_mds_pulse", {31'b0, dc_mds}, 32'd0);

    $display("[TB] store log");
    dc_req = 1'b1; dc_write = 1'b1; dc_addr = 32'h40000010; dc_wdata = 32'hDEADBEEF;
    expDc.push_back('{isLoad: 1'b0, data: 32'h0});
    tick(); dc_req = 1'b0; dc_write = 1'b0;
    checkOutput("st_mds", {31'b0, dc_mds}, 32'd1);
    checkOutput("st_valid", {31'b0, st_valid}, 32'd1);
    checkOutput("st_addr", st_addr, 32'h40000010);
    checkOutput("st_data", st_data, 32'hDEADBEEF);
    st_pop = 1'b1; tick(); st_pop = 1'b0;
    checkOutput("st_valid_popped", {31'b0, st_valid}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      dc_req = 1'b1; dc_write = 1'b1; dc_addr = 32'(i * 4); dc_wdata = ~32'(i);
      expDc.push_back('{isLoad: 1'b0, data: 32'h0});
      tick();
    end
    dc_req = 1'b0; dc_write = 1'b0;
    checkOutput("st_ovf_set", {31'b0, err_flags[1]}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("st_fill_addr", st_addr, 32'(i * 4));
      checkOutput("st_fill_data", st_data, ~32'(i));
      st_pop = 1'b1; tick(); st_pop = 1'b0;
    end
    checkOutput("st_drained", {31'b0, st_valid}, 32'd0);
    st_pop = 1'b1; tick(); st_pop = 1'b0;
    checkOutput("st_pop_empty", {31'b0, st_valid}, 32'd0);

    $display("[TB] load underflow");
    checkOutput("ld_uf_clear", {31'b0, err_flags[2]}, 32'd0);
    dc_req = 1'b1; dc_write = 1'b0;
    expDc.push_back('{isLoad: 1'b1, data: 32'h0});
    tick(); dc_req = 1'b0;
    n = 0;
    while (!dc_mds && n < 10) begin
      tick();
      n++;
    end
    checkOutput("ld_uf_mds_bound", {31'b0, dc_mds}, 32'd1);
    checkOutput("ld_uf_rdata", dc_rdata, 32'd0);
    checkOutput("ld_uf_set", {31'b0, err_flags[2]}, 32'd1);
    tick();

    $display("[TB] reset during load wait");
    ld_push = 1'b1; ld_wdata = 32'h55; tick(); ld_push = 1'b0;
    dc_req = 1'b1; dc_write = 1'b0;
    tick(); dc_req = 1'b0;
    checkOutput("wait_hold", {31'b0, dc_hold}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("abort_hold", {31'b0, dc_hold}, 32'd0);
    checkOutput("abort_mds", {31'b0, dc_mds}, 32'd0);
    checkOutput("abort_err", {29'b0, err_flags}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("abort_no_mds", {31'b0, dc_mds}, 32'd0);
    end

    checkOutput("ic_queue_drained", 32'(expIc.size()), 32'd0);
    checkOutput("dc_queue_drained", 32'(expDc.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/leon_stim_responder.md
Name: leon_stim_responder

Overview:
- Parametrised, synthesizable stimulus/response model for the integer unit's cache-side ports.
- Replaces per-call, unclocked test driving of instruction and data words with queued, clocked responses.
- Instruction FIFO feeds fetches; load-data FIFO answers loads after a programmable latency; store log FIFO records every store for scoreboard readback.
- Sits between the bench and the IU cache ports; bench pushes and pops through simple valid interfaces.

Parameters:
- INST_DEPTH, 16, instruction FIFO entries (power of 2)
- LD_DEPTH, 8, load-data FIFO entries (power of 2)
- ST_DEPTH, 8, store-log FIFO entries (power of 2)
- LOAD_LAT, 2, wait cycles between load request and response (0..15)
- NOP_INST, 32'h01000000, word returned on instruction underflow

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_push  in  1  bench pushes instruction word
- inst_wdata  in  32  instruction word
- inst_full  out  1  instruction FIFO full
- ld_push  in  1  bench pushes load response word
- ld_wdata  in  32  load response word
- ld_full  out  1  load FIFO full
- ic_req  in  1  core fetch request
- ic_data  out  32  fetched instruction
- ic_valid  out  1  ic_data valid this cycle
- ic_hold  out  1  fetch stall (optional feature only; else 0)
- dc_req  in  1  core data access request
- dc_write  in  1  1 = store, 0 = load
- dc_addr  in  32  data address
- dc_wdata  in  32  store data
- dc_rdata  out  32  load data
- dc_mds  out  1  data strobe, one-cycle pulse
- dc_hold  out  1  data stall
- st_pop  in  1  bench pops store log
- st_addr  out  32  head store address
- st_data  out  32  head store data
- st_valid  out  1  store log non-empty
- ic_underflow_cnt  out  16  fetches answered with NOP_INST, saturating
- err_flags  out  3  sticky bits: {ld_underflow, st_ovf, inst_ovf}

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - rst clears all FIFOs and counters and the FSM goes to IDLE.
  - Reset values: ic_data=NOP_INST, ic_valid=0, ic_hold=0, dc_rdata=0, dc_mds=0, dc_hold=0, st_valid=0, ic_underflow_cnt=0, err_flags=0.
  - Reset mid-load aborts the load: no mds, hold drops next cycle.
- Instruction path:
  - ic_req sampled with ic_hold=0 → next cycle ic_valid=1 and ic_data=FIFO head, which is popped.
  - If the FIFO is empty: ic_data=NOP_INST and ic_underflow_cnt increments, saturating at 16'hFFFF.
  - No ic_req → ic_valid=0 and ic_data holds its last value.
- FIFO push rules:
  - Push to a full FIFO with no same-cycle pop is dropped and sets the sticky overflow bit (inst_ovf for the instruction FIFO).
  - Simultaneous push and pop on a full FIFO: both are accepted.
  - Pointers wrap modulo depth; full/empty use an extra pointer bit.
- Data FSM, states IDLE, WAIT, RESP:
  - IDLE with dc_req & dc_write: {dc_addr, dc_wdata} is pushed to the store log; dc_mds=1 next cycle; stay IDLE.
  - Store to a full log is dropped and sets st_ovf; dc_mds still pulses.
  - IDLE with dc_req & !dc_write: dc_hold=1 from the next cycle. With LOAD_LAT>0, go to WAIT and load cnt=LOAD_LAT-1; with LOAD_LAT=0, go straight to RESP.
  - WAIT: dc_hold=1 and cnt decrements; cnt==0 → RESP.
  - RESP: dc_rdata=load FIFO head (popped), or 0 and set ld_underflow if empty; dc_mds=1 and dc_hold=0 next cycle; return to IDLE.
  - Load latency from request to mds = LOAD_LAT+2 cycles.
  - dc_req outside IDLE is ignored; the core must hold off while dc_hold=1.
- Store log readback:
  - st_addr/st_data show the head entry combinationally.
  - st_pop with st_valid=1 pops; st_pop on empty is ignored.

Optional Feature:
- Macro: LEON_STIM_STALL_EN.
- Defined:
  - A 16-bit Galois LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle.
  - When LFSR[1:0]==2'b00, ic_hold=1 for that cycle, ic_req is not serviced and nothing pops.
  - LFSR resets to its seed.
- Undefined: ic_hold is tied 0 and no LFSR logic exists.

Decomposition:
- Package leon_stim_pkg holds:
  - NOP_INST default constant
  - data FSM state enum {IDLE, WAIT, RESP}
  - store record typedef {addr[31:0], data[31:0]}
  - LFSR seed/taps constants
- Sub-module stim_fifo: generic sync FIFO parametrised by WIDTH and DEPTH, with push/pop/full/empty; instantiated three times.

Test Plan:
- Push 8'h... sequence 32'h8E00C002, 32'h01000000; pulse ic_req twice → ic_data shows those words in order, ic_valid high one cycle after each request.
- Empty instruction FIFO, 3 ic_req → ic_data=32'h01000000 three times, ic_underflow_cnt=3.
- LOAD_LAT=2, ld_push 32'h00000013, load request → dc_hold high 3 cycles, dc_mds pulses with dc_rdata=32'h13 at request+4; repeat with LOAD_LAT=0 → mds at request+2.
- Store addr 32'h40000010, data 32'hDEADBEEF → st_valid=1 and matching head; st_pop → st_valid=0. Fill ST_DEPTH+1 stores → err_flags[1]=1.
- Load with empty load FIFO → dc_rdata=0, err_flags[2]=1; assert rst during WAIT → dc_hold=0 next cycle, no mds.
- With LEON_STIM_STALL_EN defined: continuous ic_req over 64 cycles → ic_hold pattern matches the reference LFSR and no instruction is lost or duplicated.
